// File: rtl/pwm_soc_pkg.sv
// Shared opcodes, response bytes and FSM state types for the PWM/UART SoC.
package pwm_soc_pkg;

  localparam logic [7:0] OP_DUTY   = 8'h44;
  localparam logic [7:0] OP_PERIOD = 8'h50;
  localparam logic [7:0] OP_EN     = 8'h45;
  localparam logic [7:0] OP_DIS    = 8'h58;
  localparam logic [7:0] OP_READ   = 8'h52;

  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h3F;

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;
  typedef enum logic       {CMD_OP, CMD_ARG} cmd_state_e;

endpackage

// File: rtl/pwm_uart_soc_if.sv
// Board-facing pins of the SoC: serial RX/TX and the PWM output.
interface pwm_uart_soc_if;
  logic RXD;
  logic TXD;
  logic PWM;

  modport master (output RXD, input TXD, input PWM);
  modport slave  (input RXD, output TXD, output PWM);
endinterface

// File: rtl/pwm_uart_rx.sv
// UART 8N1 receiver: 2-FF synchronizer, falling-edge start detect with a
// mid-start-bit glitch recheck, LSB-first sampling, bad stop bits drop the byte.
module pwm_uart_rx
  import pwm_soc_pkg::*;
#(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic       o_valid,
  output logic [7:0] o_data
);

  localparam int            CW        = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

  rx_state_e     r_state;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit;
  logic          r_sync1, r_sync2, r_prev, r_valid;
  logic [7:0]    r_shift, r_data;
  logic          w_bit_end;

  assign w_bit_end = (r_cnt == BIT_LAST);

  // Start needs a high-to-low edge, so after a framing error the line must
  // return high before another frame can begin.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
      r_prev  <= 1'b1;
      r_state <= RX_IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_sync1 <= i_rxd;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_valid <= 1'b0;
      case (r_state)
        RX_IDLE: begin
          if (r_prev && !r_sync2) begin
            r_state <= RX_START;
            r_cnt   <= '0;
          end
        end
        RX_START: begin
          if (r_cnt == HALF_LAST) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= r_sync2 ? RX_IDLE : RX_DATA;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_DATA: begin
          if (w_bit_end) begin
            r_cnt <= '0;
            r_bit <= r_bit + 1'b1;
            if (r_bit == 3'd7) r_state <= RX_STOP;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        RX_STOP: begin
          if (w_bit_end) begin
            r_state <= RX_IDLE;
            r_valid <= r_sync2;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: r_state <= RX_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (r_state == RX_DATA && w_bit_end) r_shift <= {r_sync2, r_shift[7:1]};
    if (r_state == RX_STOP && w_bit_end) r_data  <= r_shift;
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;

endmodule

// File: rtl/pwm_uart_soc.sv
// PWM peripheral controlled over UART: byte command decoder, response
// transmitter with a one-entry pending slot, and a shadowed PWM generator.
module pwm_uart_soc
  import pwm_soc_pkg::*;
#(
  parameter int CLK_FREQ = 12000000,
  parameter int BAUD     = 115200,
  parameter int PWM_W    = 8
) (
  input  logic           CLK,
  input  logic           RESET,
  pwm_uart_soc_if.slave  bus
);

  localparam int               CLKS_PER_BIT = CLK_FREQ / BAUD;
  localparam int               CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0]    BIT_LAST     = CW'(CLKS_PER_BIT - 1);
  localparam logic [PWM_W-1:0] PER_RST      = PWM_W'(255);

  logic       w_rx_valid;
  logic [7:0] w_rx_data;

  pwm_uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .i_clk   (CLK),
    .i_rst_n (RESET),
    .i_rxd   (bus.RXD),
    .o_valid (w_rx_valid),
    .o_data  (w_rx_data)
  );

  cmd_state_e       r_cmd_st;
  logic [7:0]       r_op;
  logic [PWM_W-1:0] r_per_sh, r_duty_sh, r_per, r_duty, r_cnt;
  logic             r_en, r_pwm;
  logic             w_rsp_vld;
  logic [7:0]       w_rsp;

  always_comb begin
    w_rsp_vld = 1'b0;
    w_rsp     = RSP_ACK;
    if (w_rx_valid) begin
      if (r_cmd_st == CMD_ARG) begin
        w_rsp_vld = 1'b1;
      end else begin
        case (w_rx_data)
          OP_DUTY, OP_PERIOD: w_rsp_vld = 1'b0;
          OP_EN, OP_DIS:      w_rsp_vld = 1'b1;
          OP_READ: begin
            w_rsp_vld = 1'b1;
            w_rsp     = 8'(r_duty_sh);
          end
          default: begin
            w_rsp_vld = 1'b1;
            w_rsp     = RSP_ERR;
          end
        endcase
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cmd_st  <= CMD_OP;
      r_op      <= '0;
      r_per_sh  <= PER_RST;
      r_duty_sh <= '0;
      r_en      <= 1'b1;
    end else if (w_rx_valid) begin
      if (r_cmd_st == CMD_ARG) begin
        r_cmd_st <= CMD_OP;
        if (r_op == OP_DUTY) r_duty_sh <= PWM_W'(w_rx_data);
        else                 r_per_sh  <= PWM_W'(w_rx_data);
      end else begin
        case (w_rx_data)
          OP_DUTY, OP_PERIOD: begin
            r_cmd_st <= CMD_ARG;
            r_op     <= w_rx_data;
          end
          OP_EN:   r_en <= 1'b1;
          OP_DIS:  r_en <= 1'b0;
          default: ;
        endcase
      end
    end
  end

  // Shadow registers move to the active set only at wrap, so a running
  // cycle always completes with the settings it started with.
  logic w_wrap;
  assign w_wrap = (r_cnt == r_per);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_cnt  <= '0;
      r_per  <= PER_RST;
      r_duty <= '0;
      r_pwm  <= 1'b0;
    end else begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
      if (w_wrap) begin
        r_per  <= r_per_sh;
        r_duty <= r_duty_sh;
      end
      r_pwm <= r_en && (r_cnt < r_duty);
    end
  end

  tx_state_e     r_tx_st;
  logic [CW-1:0] r_tx_cnt;
  logic [2:0]    r_tx_bit;
  logic          r_txd, r_pend_vld;
  logic [7:0]    r_tx_shift, r_pend;
  logic          w_tx_load, w_tx_end, w_pend_wr;

  assign w_tx_load = (r_tx_st == TX_IDLE) && r_pend_vld;
  assign w_tx_end  = (r_tx_cnt == BIT_LAST);
  assign w_pend_wr = w_rsp_vld && (!r_pend_vld || w_tx_load);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_tx_st    <= TX_IDLE;
      r_tx_cnt   <= '0;
      r_tx_bit   <= '0;
      r_txd      <= 1'b1;
      r_pend_vld <= 1'b0;
    end else begin
      if (w_tx_load) r_pend_vld <= 1'b0;
      if (w_pend_wr) r_pend_vld <= 1'b1;
      case (r_tx_st)
        TX_IDLE: begin
          if (w_tx_load) begin
            r_tx_st  <= TX_START;
            r_txd    <= 1'b0;
            r_tx_cnt <= '0;
          end
        end
        TX_START: begin
          if (w_tx_end) begin
            r_tx_st  <= TX_DATA;
            r_txd    <= r_tx_shift[0];
            r_tx_cnt <= '0;
            r_tx_bit <= '0;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_DATA: begin
          if (w_tx_end) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_tx_st <= TX_STOP;
              r_txd   <= 1'b1;
            end else begin
              r_tx_bit <= r_tx_bit + 1'b1;
              r_txd    <= r_tx_shift[1];
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        TX_STOP: begin
          if (w_tx_end) r_tx_st  <= TX_IDLE;
          else          r_tx_cnt <= r_tx_cnt + 1'b1;
        end
        default: r_tx_st <= TX_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_tx_load)                          r_tx_shift <= r_pend;
    else if (r_tx_st == TX_DATA && w_tx_end) r_tx_shift <= {1'b0, r_tx_shift[7:1]};
    if (w_pend_wr) r_pend <= w_rsp;
  end

  assign bus.TXD = r_txd;
  assign bus.PWM = r_pwm;

endmodule

// File: tb/tb_pwm_uart_soc.sv
// Directed plus randomized bench for pwm_uart_soc at 10 clocks per UART bit.
module tb_pwm_uart_soc;
  import pwm_soc_pkg::*;

  localparam int CPB = 10;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pwm_uart_soc_if bus ();

  pwm_uart_soc #(.CLK_FREQ(1000000), .BAUD(100000), .PWM_W(8)) dut (
    .CLK   (clk),
    .RESET (rst_n),
    .bus   (bus)
  );

  int n_chk  = 0;
  int n_pass = 0;
  int n_fail = 0;

  // Reference model: register file as the command set defines it.
  int m_duty, m_period, m_en;
  logic [7:0] txq[$];

  initial begin : tx_mon
    logic [7:0] b;
    forever begin
      @(negedge bus.TXD);
      repeat (CPB / 2) @(negedge clk);
      if (bus.TXD == 1'b0) begin
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = bus.TXD;
        end
        repeat (CPB) @(negedge clk);
        txq.push_back(b);
      end
    end
  end

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop, input int tail);
    tick(1);
    bus.RXD = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      bus.RXD = b[i];
      tick(CPB);
    end
    bus.RXD = stop;
    tick(CPB + tail);
    bus.RXD = 1'b1;
  endtask

  task automatic expect_rsp(input string tag, input logic [7:0] exp);
    int t = 0;
    while (txq.size() == 0 && t < 400) begin
      tick(1);
      t++;
    end
    if (txq.size() == 0) check(tag, 32'h100, {24'h0, exp});
    else                 check(tag, {24'h0, txq.pop_front()}, {24'h0, exp});
  endtask

  task automatic wr(input logic [7:0] op, input logic [7:0] arg, input string tag);
    send_frame(op, 1'b1, 0);
    send_frame(arg, 1'b1, 0);
    if (op == OP_DUTY) m_duty = int'(arg);
    else               m_period = int'(arg);
    expect_rsp(tag, RSP_ACK);
  endtask

  task automatic op1(input logic [7:0] b, input string tag);
    logic [7:0] rsp;
    case (b)
      OP_EN:   begin rsp = RSP_ACK; m_en = 1; end
      OP_DIS:  begin rsp = RSP_ACK; m_en = 0; end
      OP_READ: rsp = 8'(m_duty);
      default: rsp = RSP_ERR;
    endcase
    send_frame(b, 1'b1, 0);
    expect_rsp(tag, rsp);
  endtask

  // High clocks in a window that is a whole number of PWM cycles.
  function automatic int exp_high(input int window);
    int per = m_period + 1;
    int hi  = (m_duty < per) ? m_duty : per;
    if (m_en == 0) return 0;
    return (window / per) * hi;
  endfunction

  task automatic measure_high(input int n, output int hi);
    hi = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (bus.PWM === 1'b1) hi++;
    end
  endtask

  task automatic check_pwm(input string tag);
    int hi, n;
    tick(300);
    n = 4 * (m_period + 1);
    measure_high(n, hi);
    check(tag, hi, exp_high(n));
  endtask

  task automatic measure_shape(output int hi_len, output int per_len);
    logic prev, rise;
    int t;
    hi_len = -1;
    per_len = -1;
    t = 0;
    rise = 1'b0;
    @(negedge clk);
    prev = bus.PWM;
    while (!rise && t < 600) begin
      @(negedge clk);
      t++;
      rise = !prev && (bus.PWM === 1'b1);
      prev = bus.PWM;
    end
    if (!rise) return;
    hi_len = 0;
    per_len = 0;
    while (prev && per_len < 600) begin
      hi_len++;
      per_len++;
      @(negedge clk);
      prev = bus.PWM;
    end
    while (!prev && per_len < 600) begin
      per_len++;
      @(negedge clk);
      prev = bus.PWM;
    end
  endtask

  initial begin : main
    int hi, per, p, d;
    logic [7:0] junk;
    bus.RXD  = 1'b1;
    rst_n    = 1'b0;
    m_duty   = 0;
    m_period = 255;
    m_en     = 1;

    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("rst_txd", {31'h0, bus.TXD}, 32'h1);
      check("rst_pwm", {31'h0, bus.PWM}, 32'h0);
    end
    tick(1);
    rst_n = 1'b1;
    measure_high(300, hi);
    check("post_rst_pwm_low", hi, 0);

    wr(OP_DUTY, 8'h40, "duty40_ack");
    check_pwm("duty40_pwm");

    wr(OP_PERIOD, 8'h09, "per9_ack");
    wr(OP_DUTY, 8'h03, "duty3_ack");
    check_pwm("p9d3_pwm");
    measure_shape(hi, per);
    check("p9d3_high_len", hi, 3);
    check("p9d3_period", per, 10);

    wr(OP_DUTY, 8'h0F, "duty15_ack");
    check_pwm("duty_gt_per_pwm");
    wr(OP_DUTY, 8'h03, "duty3b_ack");
    tick(300);

    send_frame(OP_DIS, 1'b1, 0);
    @(negedge clk);
    check("dis_fast_low", {31'h0, bus.PWM}, 32'h0);
    m_en = 0;
    expect_rsp("dis_ack", RSP_ACK);
    check_pwm("dis_pwm");
    op1(OP_EN, "en_ack");
    check_pwm("en_pwm");
    measure_shape(hi, per);
    check("en_high_len", hi, 3);
    check("en_period", per, 10);

    op1(OP_READ, "read_duty3");
    op1(8'h7A, "bad_op_err");
    check_pwm("bad_op_unchanged");

    tick(1);
    bus.RXD = 1'b0;
    tick(3);
    bus.RXD = 1'b1;
    tick(300);
    check("glitch_no_rsp", txq.size(), 0);

    send_frame(OP_DIS, 1'b0, 25);
    tick(300);
    check("frame_err_no_rsp", txq.size(), 0);
    check_pwm("frame_err_still_en");
    op1(OP_EN, "after_frame_err_ack");

    wr(OP_DUTY, OP_READ, "arg_is_opcode_ack");
    op1(OP_READ, "arg_is_opcode_read");

    for (int k = 0; k < 6; k++) begin
      p = $urandom_range(0, 20);
      d = $urandom_range(0, p + 3);
      wr(OP_PERIOD, 8'(p), "rand_per_ack");
      wr(OP_DUTY, 8'(d), "rand_duty_ack");
      if ($urandom_range(0, 2) == 0) op1(OP_DIS, "rand_dis_ack");
      else                           op1(OP_EN, "rand_en_ack");
      check_pwm("rand_pwm");
      op1(OP_READ, "rand_read");
      do junk = 8'($urandom_range(0, 255));
      while (junk inside {OP_DUTY, OP_PERIOD, OP_EN, OP_DIS, OP_READ});
      op1(junk, "rand_bad_op");
    end

    tick(200);
    check("no_stray_rsp", txq.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pwm_uart_soc.md
Name: pwm_uart_soc

Overview:
- Minimal PWM peripheral SoC for the FPGA board.
- A UART receiver accepts byte commands that program a PWM generator's period, duty and enable.
- A UART transmitter returns an acknowledge byte or a data byte for each command.
- Top-level block: RXD/TXD go to the board's serial pins, PWM to an output pin.

Parameters:
- CLK_FREQ, 12000000: clock frequency in Hz.
- BAUD, 115200: UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD, integer-truncated; 104 at the defaults.
- PWM_W, 8: width of the period, duty and counter registers.

Ports:
- CLK  input  1  system clock.
- RESET  input  1  asynchronous, active-low reset. Asserted when RESET=0.
- RXD  input  1  UART receive, 8N1, idle high, asynchronous to CLK.
- TXD  output  1  UART transmit, 8N1, idle high.
- PWM  output  1  PWM waveform.

Behaviour:
- Reset values (RESET=0): TXD=1, PWM=0, PERIOD=255, DUTY=0, ENABLE=1, counter=0, RX/TX/command FSMs idle. Reset mid-frame aborts any RX or TX frame immediately.
- RX input conditioning: RXD passes through a 2-FF synchronizer.
- RX start detection: a synchronized falling edge while idle starts a frame. The start bit is re-checked at CLKS_PER_BIT/2; if it is high there, return to idle (glitch).
- RX data sampling: data bits are sampled every CLKS_PER_BIT clocks at mid-bit, LSB first. Then the stop bit is sampled.
- RX stop-bit handling: stop=1 produces a 1-cycle rx_valid with rx_data. Stop=0 is a framing error: the byte is discarded and the RX FSM waits for RXD high before re-arming.
- RX FSM states: IDLE, START, DATA, STOP.
- TX frame: start bit 0, 8 data bits LSB first, stop bit 1, each bit CLKS_PER_BIT clocks.
- TX busy handling: tx_start is accepted only when TX is idle. A 1-entry pending register holds the next response byte. A second response arriving while the pending register is full is dropped; the protocol timing makes this unreachable.
- Command FSM states: CMD (awaiting opcode) and ARG (awaiting argument byte, stores the opcode).
- Opcode 'D' (0x44): go to ARG. The next byte sets DUTY; respond 'K' (0x4B).
- Opcode 'P' (0x50): go to ARG. The next byte sets PERIOD; respond 'K'.
- Opcode 'E' (0x45): ENABLE=1; respond 'K'.
- Opcode 'X' (0x58): ENABLE=0; respond 'K'.
- Opcode 'R' (0x52): respond with the current DUTY byte.
- Any other opcode: respond '?' (0x3F), no register change.
- ARG state: no timeout. Any byte, including opcode values, is taken as the argument.
- PWM counter: free-running, 0..PERIOD inclusive. Wraps to 0 after PERIOD, so the cycle length is PERIOD+1 clocks.
- PWM output: registered, PWM = ENABLE && (counter < DUTY_active).
  - DUTY=0 gives a constant low.
  - DUTY > PERIOD gives a constant high.
- PWM register update timing: PERIOD and DUTY writes go to shadow registers. They are copied to the active registers when counter == PERIOD_active, i.e. at wrap, so the current cycle is never truncated.
- ENABLE timing: takes effect on the next clock. With ENABLE=0, PWM=0 and the counter keeps running.
- PERIOD=0 edge case: the counter stays at 0. PWM is constant high if DUTY ≥ 1, else low.

Decomposition:
- Shared package pwm_soc_pkg holds:
  - opcode constants (OP_DUTY, OP_PERIOD, OP_EN, OP_DIS, OP_READ);
  - response constants (RSP_ACK, RSP_ERR);
  - FSM state enums.
- Sub-module pwm_uart_rx: synchronizer plus RX FSM, outputs rx_valid/rx_data.
- TX, command decoder and PWM stay in the top module.

Test Plan:
- All scenarios use CLK_FREQ=1000000 and BAUD=100000, giving 10 clocks/bit.
- Reset: hold RESET=0 for 5 cycles with RXD=1 -> TXD=1 and PWM=0 throughout. After release, PWM stays 0 (DUTY=0).
- Duty set: send 0x44,0x40 -> TXD returns 0x4B. After the next counter wrap, PWM is high for 64 of every 256 clocks.
- Period + duty: send 0x50,0x09 then 0x44,0x03 -> two 0x4B responses. PWM period is 10 clocks with 3 high. Sending DUTY=0x0F then gives constant high.
- Disable/enable: send 0x58 -> 0x4B, PWM=0 within 2 clocks. Send 0x45 -> PWM resumes its prior duty pattern.
- Readback/error: send 0x52 -> TXD returns the current DUTY byte (e.g. 0x03). Send 0x7A -> 0x3F, registers unchanged.
- Framing/glitch: a 3-clock RXD low pulse produces no byte. A frame with stop bit 0 is discarded with no TX response. The next valid 0x45 is still acknowledged.
